// File: rtl/usb_dual_data_buffer.sv
// ============================================================================
// Module      : usb_dual_data_buffer
// Description : Independent TX and RX byte FIFOs between an AHB-side word port
//               and the USB packet encoder/decoder byte ports.
//               Optional macro USB_BUF_ERR_FLAGS_EN enables sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_dual_data_buffer #(
    parameter int  DEPTH = 64,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             flush,
    input  logic [1:0]       hsize,
    input  logic             store_tx_data,
    input  logic [31:0]      tx_data,
    input  logic             get_tx_packet_data,
    output logic [7:0]       tx_packet_data,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             get_rx_data,
    output logic [31:0]      rx_data,
    output logic [CNT_W-1:0] tx_occupancy,
    output logic [CNT_W-1:0] rx_occupancy,
    output logic             tx_error,
    output logic             rx_error
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Byte count of an AHB-side transfer; zero marks the illegal size.
    function automatic logic [2:0] size_bytes(input logic [1:0] hs);
        logic [2:0] n;
        n = 3'd0;
        case (hs)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            2'd2:    n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    logic [2:0]       w_size_n;
    logic [CNT_W-1:0] w_size_cnt;
    logic             w_size_ok;

    assign w_size_n   = size_bytes(hsize);
    assign w_size_cnt = CNT_W'(w_size_n);
    assign w_size_ok  = (hsize != 2'd3);

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [7:0]       r_tx_mem [DEPTH];
    logic [PTR_W-1:0] r_tx_wr_ptr;
    logic [PTR_W-1:0] r_tx_rd_ptr;
    logic [CNT_W-1:0] r_tx_occ;
    logic [CNT_W-1:0] w_tx_free;
    logic             w_tx_push;
    logic             w_tx_pop;

    assign w_tx_free = DEPTH_CNT - r_tx_occ;
    assign w_tx_push = store_tx_data && w_size_ok && (w_tx_free >= w_size_cnt);
    assign w_tx_pop  = get_tx_packet_data && (r_tx_occ != '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_occ    <= '0;
        end else if (flush) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_occ    <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + PTR_W'(w_size_n);
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + PTR_W'(1);
            end
            r_tx_occ <= r_tx_occ + (w_tx_push ? w_size_cnt : '0)
                                 - (w_tx_pop ? CNT_W'(1) : '0);
        end
    end

    // Storage is not reset; the pointers alone define valid content.
    always_ff @(posedge clk) begin
        if (w_tx_push && !flush) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < w_size_n) begin
                    r_tx_mem[r_tx_wr_ptr + PTR_W'(k)] <= tx_data[8*k +: 8];
                end
            end
        end
    end

    assign tx_packet_data = (r_tx_occ == '0) ? 8'h00 : r_tx_mem[r_tx_rd_ptr];
    assign tx_occupancy   = r_tx_occ;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [7:0]       r_rx_mem [DEPTH];
    logic [PTR_W-1:0] r_rx_wr_ptr;
    logic [PTR_W-1:0] r_rx_rd_ptr;
    logic [CNT_W-1:0] r_rx_occ;
    logic [31:0]      r_rx_data;
    logic [31:0]      w_rx_word;
    logic             w_rx_push;
    logic             w_rx_pop;

    assign w_rx_push = store_rx_packet_data && (r_rx_occ != DEPTH_CNT);
    assign w_rx_pop  = get_rx_data && w_size_ok && (r_rx_occ >= w_size_cnt);

    // Oldest byte lands in [7:0]; bytes beyond the transfer size read as zero.
    always_comb begin
        w_rx_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_size_n) begin
                w_rx_word[8*k +: 8] = r_rx_mem[r_rx_rd_ptr + PTR_W'(k)];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_occ    <= '0;
            r_rx_data   <= '0;
        end else if (clear) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_occ    <= '0;
            r_rx_data   <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + PTR_W'(1);
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + PTR_W'(w_size_n);
                r_rx_data   <= w_rx_word;
            end
            r_rx_occ <= r_rx_occ + (w_rx_push ? CNT_W'(1) : '0)
                                 - (w_rx_pop ? w_size_cnt : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push && !clear) begin
            r_rx_mem[r_rx_wr_ptr] <= rx_packet_data;
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_occupancy = r_rx_occ;

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
`ifdef USB_BUF_ERR_FLAGS_EN
    logic r_tx_error;
    logic r_rx_error;
    logic w_tx_err_evt;
    logic w_rx_err_evt;

    // Illegal hsize is ignored outright and never counts as an error.
    assign w_tx_err_evt = (store_tx_data && w_size_ok && !w_tx_push)
                       || (get_tx_packet_data && (r_tx_occ == '0));
    assign w_rx_err_evt = (store_rx_packet_data && !w_rx_push)
                       || (get_rx_data && w_size_ok && !w_rx_pop);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tx_error <= 1'b0;
            r_rx_error <= 1'b0;
        end else begin
            if (flush) begin
                r_tx_error <= 1'b0;
            end else if (w_tx_err_evt) begin
                r_tx_error <= 1'b1;
            end
            if (clear) begin
                r_rx_error <= 1'b0;
            end else if (w_rx_err_evt) begin
                r_rx_error <= 1'b1;
            end
        end
    end

    assign tx_error = r_tx_error;
    assign rx_error = r_rx_error;
`else
    assign tx_error = 1'b0;
    assign rx_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_dual_data_buffer.sv
// ============================================================================
// Module      : tb_usb_dual_data_buffer
// Description : Scoreboard bench for usb_dual_data_buffer (DEPTH=64); error
//               expectations follow macro USB_BUF_ERR_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_dual_data_buffer;

    localparam int DEPTH = 64;
    localparam int CNT_W = 7;
`ifdef USB_BUF_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             clear = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       hsize = 2'd0;
    logic             store_tx_data = 1'b0;
    logic [31:0]      tx_data = '0;
    logic             get_tx_packet_data = 1'b0;
    logic [7:0]       tx_packet_data;
    logic             store_rx_packet_data = 1'b0;
    logic [7:0]       rx_packet_data = '0;
    logic             get_rx_data = 1'b0;
    logic [31:0]      rx_data;
    logic [CNT_W-1:0] tx_occupancy;
    logic [CNT_W-1:0] rx_occupancy;
    logic             tx_error;
    logic             rx_error;

    usb_dual_data_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .flush                (flush),
        .hsize                (hsize),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .tx_occupancy         (tx_occupancy),
        .rx_occupancy         (rx_occupancy),
        .tx_error             (tx_error),
        .rx_error             (rx_error)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  tx_exp_q [$];
    logic [31:0] rx_exp_q [$];
    logic        rx_pending = 1'b0;
    logic [7:0]  mon_tx;
    logic [31:0] mon_rx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Monitor: TX byte observed while a pop is presented, RX word one edge after a get.
    always @(negedge clk) begin
        if (rx_pending) begin
            rx_pending = 1'b0;
            if (rx_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %h expected none", rx_data);
            end else begin
                mon_rx = rx_exp_q.pop_front();
                check("rx_data", rx_data, mon_rx);
            end
        end
        if (get_rx_data && n_rst) rx_pending = 1'b1;
        if (get_tx_packet_data && n_rst) begin
            if (tx_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %h expected none", tx_packet_data);
            end else begin
                mon_tx = tx_exp_q.pop_front();
                check("tx_packet_data", {24'h0, tx_packet_data}, {24'h0, mon_tx});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [1:0] hs, input logic [31:0] d, input logic record);
        hsize         = hs;
        tx_data       = d;
        store_tx_data = 1'b1;
        if (record && hs != 2'd3) begin
            for (int k = 0; k < (1 << hs); k++) tx_exp_q.push_back(d[8*k +: 8]);
        end
        tick();
        store_tx_data = 1'b0;
    endtask

    task automatic tx_pop(input int n);
        get_tx_packet_data = 1'b1;
        repeat (n) tick();
        get_tx_packet_data = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_packet_data       = b;
        store_rx_packet_data = 1'b1;
        tick();
        store_rx_packet_data = 1'b0;
    endtask

    task automatic rx_get(input logic [1:0] hs, input logic [31:0] want);
        rx_exp_q.push_back(want);
        hsize       = hs;
        get_rx_data = 1'b1;
        tick();
        get_rx_data = 1'b0;
    endtask

    task automatic pulse_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_occ", 32'(tx_occupancy), 32'd0);
        check("rst_rx_occ", 32'(rx_occupancy), 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_tx_head", 32'(tx_packet_data), 32'd0);
        check("rst_tx_err", 32'(tx_error), 32'd0);
        n_rst = 1'b1;
        tick();

        // Single word write then drain, including one pop on empty
        tx_write(2'd2, 32'h0000B5F0, 1'b1);
        check("t1_tx_occ", 32'(tx_occupancy), 32'd4);
        check("t1_tx_head", 32'(tx_packet_data), 32'hF0);
        tx_exp_q.push_back(8'h00);
        tx_pop(5);
        check("t1_tx_occ_empty", 32'(tx_occupancy), 32'd0);
        check("t1_tx_err", 32'(tx_error), 32'(ERR_EN));
        pulse_flush();
        check("t1_tx_err_flush", 32'(tx_error), 32'd0);

        // Illegal size is ignored
        tx_write(2'd3, 32'h12345678, 1'b0);
        check("hs3_tx_occ", 32'(tx_occupancy), 32'd0);
        check("hs3_tx_err", 32'(tx_error), 32'd0);

        // Fill to full, reject an extra byte, then flush
        for (int i = 0; i < 16; i++) tx_write(2'd2, 32'h01010101 * (i + 1), 1'b0);
        check("t2_tx_full", 32'(tx_occupancy), 32'd64);
        tx_write(2'd0, 32'h000000AA, 1'b0);
        check("t2_tx_reject_occ", 32'(tx_occupancy), 32'd64);
        check("t2_tx_reject_err", 32'(tx_error), 32'(ERR_EN));
        check("t2_tx_head", 32'(tx_packet_data), 32'h01);
        pulse_flush();
        check("t2_flush_occ", 32'(tx_occupancy), 32'd0);
        check("t2_flush_err", 32'(tx_error), 32'd0);
        check("t2_flush_head", 32'(tx_packet_data), 32'd0);

        // RX halfword read, rejected word read, byte read
        rx_push(8'h11);
        rx_push(8'h22);
        rx_push(8'h33);
        check("t3_rx_occ", 32'(rx_occupancy), 32'd3);
        rx_get(2'd1, 32'h00002211);
        check("t3_rx_occ_after", 32'(rx_occupancy), 32'd1);
        rx_get(2'd2, 32'h00002211);
        check("t3_rx_occ_reject", 32'(rx_occupancy), 32'd1);
        check("t3_rx_err", 32'(rx_error), 32'(ERR_EN));
        rx_get(2'd0, 32'h00000033);
        check("t3_rx_occ_empty", 32'(rx_occupancy), 32'd0);
        pulse_clear();
        check("t3_rx_err_clear", 32'(rx_error), 32'd0);

        // Pointer wrap and simultaneous push/pop
        for (int i = 0; i < 15; i++) tx_write(2'd2, 32'h03020100 + 32'h04040404 * i, 1'b1);
        check("t4_tx_occ60", 32'(tx_occupancy), 32'd60);
        tx_pop(60);
        tx_write(2'd2, 32'hDEADBEEF, 1'b1);
        tx_pop(4);
        check("t4_tx_occ_wrap", 32'(tx_occupancy), 32'd0);
        tx_write(2'd1, 32'h0000A2A1, 1'b1);
        tx_write(2'd0, 32'h000000A3, 1'b1);
        check("t4_tx_occ3", 32'(tx_occupancy), 32'd3);
        hsize              = 2'd0;
        tx_data            = 32'h000000A4;
        tx_exp_q.push_back(8'hA4);
        store_tx_data      = 1'b1;
        get_tx_packet_data = 1'b1;
        tick();
        store_tx_data      = 1'b0;
        get_tx_packet_data = 1'b0;
        check("t4_tx_occ_pushpop", 32'(tx_occupancy), 32'd3);
        tx_pop(3);
        check("t4_tx_occ_end", 32'(tx_occupancy), 32'd0);

        // Asynchronous reset with both FIFOs loaded
        rx_push(8'h01);
        rx_push(8'h02);
        rx_push(8'h03);
        rx_get(2'd0, 32'h00000001);
        rx_get(2'd2, 32'h00000001);
        for (int i = 4; i <= 10; i++) rx_push(8'(i));
        rx_get(2'd2, 32'h05040302);
        tx_write(2'd2, 32'h44332211, 1'b0);
        tx_write(2'd2, 32'h88776655, 1'b0);
        tx_write(2'd1, 32'h0000AA99, 1'b0);
        tick();
        check("t5_tx_occ", 32'(tx_occupancy), 32'd10);
        check("t5_rx_occ", 32'(rx_occupancy), 32'd5);
        check("t5_rx_err_pre", 32'(rx_error), 32'(ERR_EN));
        n_rst = 1'b0;
        #1;
        check("t5_rst_tx_occ", 32'(tx_occupancy), 32'd0);
        check("t5_rst_rx_occ", 32'(rx_occupancy), 32'd0);
        check("t5_rst_rx_data", rx_data, 32'd0);
        check("t5_rst_tx_head", 32'(tx_packet_data), 32'd0);
        check("t5_rst_rx_err", 32'(rx_error), 32'd0);
        check("t5_rst_tx_err", 32'(tx_error), 32'd0);
        tick();
        n_rst = 1'b1;
        tick();

        // clear beats same-cycle RX push and get
        rx_push(8'hAA);
        rx_push(8'hBB);
        rx_exp_q.push_back(32'h0);
        hsize                = 2'd0;
        rx_packet_data       = 8'hCC;
        clear                = 1'b1;
        store_rx_packet_data = 1'b1;
        get_rx_data          = 1'b1;
        tick();
        clear                = 1'b0;
        store_rx_packet_data = 1'b0;
        get_rx_data          = 1'b0;
        check("t6_rx_occ", 32'(rx_occupancy), 32'd0);
        check("t6_rx_data", rx_data, 32'd0);

        repeat (3) tick();
        check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
        check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/usb_dual_data_buffer.md
USB_DUAL_DATA_BUFFER -- requirements
Module: usb_dual_data_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, bytes per FIFO (power of 2, >=4).
REQ-002 SHALL have derived localparam CNT_W = $clog2(DEPTH)+1, occupancy width.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port n_rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have port clear  in  1  empties RX FIFO, clears rx_error.
REQ-006 SHALL have port flush  in  1  empties TX FIFO, clears tx_error.
REQ-007 SHALL have port hsize  in  2  transfer size for AHB-side push/pop: 0=1B, 1=2B, 2=4B, 3=invalid.
REQ-008 SHALL have port store_tx_data  in  1  push hsize bytes of tx_data into TX FIFO.
REQ-009 SHALL have port tx_data  in  32  AHB write data, byte 0 = [7:0].
REQ-010 SHALL have port get_tx_packet_data  in  1  TX encoder pops one byte.
REQ-011 SHALL have port tx_packet_data  out  8  TX FIFO head byte (show-ahead).
REQ-012 SHALL have port store_rx_packet_data  in  1  RX decoder pushes one byte.
REQ-013 SHALL have port rx_packet_data  in  8  RX decoder byte.
REQ-014 SHALL have port get_rx_data  in  1  pop hsize bytes from RX FIFO to rx_data.
REQ-015 SHALL have port rx_data  out  32  registered AHB read data.
REQ-016 SHALL have ports tx_occupancy / rx_occupancy  out  CNT_W  byte counts, 0..DEPTH.
REQ-017 SHALL have ports tx_error / rx_error  out  1  sticky overflow/underflow flags.

Function
REQ-018 Each FIFO SHALL be a DEPTH-byte circular buffer; read/write pointers wrap modulo DEPTH.
REQ-019 store_tx_data SHALL write n=1<<hsize bytes, little-endian (tx_data[7:0] first), in one cycle.
REQ-020 store_tx_data with free space (DEPTH - tx_occupancy) < n SHALL write nothing (all-or-nothing).
REQ-021 store_tx_data or get_rx_data with hsize=3 SHALL be ignored, no state change.
REQ-022 tx_packet_data SHALL combinationally show the head byte; 8'h00 when TX empty.
REQ-023 get_tx_packet_data on empty TX SHALL not move pointers.
REQ-024 store_rx_packet_data on full RX SHALL drop the byte.
REQ-025 get_rx_data SHALL, at next edge, load rx_data with n bytes (oldest in [7:0]), upper bytes zero; latency 1 cycle.
REQ-026 get_rx_data with rx_occupancy < n SHALL leave rx_data and RX FIFO unchanged.
REQ-027 Push/pop legality SHALL be judged on start-of-cycle occupancy; simultaneous legal push and pop on one FIFO SHALL both occur, occupancy += n_push - n_pop.
REQ-028 flush SHALL override same-cycle TX push/pop; clear SHALL override same-cycle RX push/pop and get_rx_data (rx_data reset to 0).
REQ-029 TX and RX paths SHALL be fully independent; same-cycle activity on both is legal.

Reset
REQ-030 n_rst low SHALL immediately zero all pointers, occupancies, rx_data, tx_error, rx_error; tx_packet_data reads 0.
REQ-031 Reset mid-transfer SHALL discard all buffered data; FIFO storage contents need not be reset.

Configuration
REQ-032 Macro USB_BUF_ERR_FLAGS_EN defined: tx_error sets on rejected TX push (REQ-020) or empty TX pop (REQ-023); rx_error sets on dropped RX byte (REQ-024) or rejected get_rx_data (REQ-026); flags persist until flush/clear/reset.
REQ-033 Macro undefined: tx_error and rx_error ports SHALL exist and be tied 0; all other behaviour identical.

Verification (DEPTH=64, USB_BUF_ERR_FLAGS_EN defined)
REQ-034 After reset: store_tx_data, hsize=2, tx_data=32'h0000B5F0 -> tx_occupancy=4, tx_packet_data=F0; 4 pops yield F0,B5,00,00, then 00 with occupancy 0.
REQ-035 Fill TX with 16 word writes (occupancy 64), then 1-byte write -> rejected, occupancy stays 64, tx_error=1; flush -> occupancy 0, tx_error=0.
REQ-036 Push RX bytes 11,22,33; get_rx_data hsize=1 -> rx_data=32'h00002211 next cycle, rx_occupancy=1; get_rx_data hsize=2 -> rejected, rx_data unchanged, rx_error=1.
REQ-037 Wrap: 60 TX bytes pushed and popped, then word 32'hDEADBEEF -> pops EF,BE,AD,DE across pointer wrap; same-cycle push(hsize=0)/pop with occupancy 3 -> stays 3.
REQ-038 Assert n_rst low mid-stream with tx_occupancy=10, rx_occupancy=5 -> all occupancies, rx_data, error flags 0 immediately, before next clock edge.
REQ-039 clear asserted same cycle as store_rx_packet_data and get_rx_data -> rx_occupancy=0, rx_data=0.
